// File: rtl/reorder_buffer_if.sv
// Purpose: bundles the reorder buffer's issue, writeback, lookup, commit and flush signals.
// Ports: slave modport = ROB side (issue/wb/search ids in; full, ids, search data, commit, clear out).
//        master modport = environment side (decoder, CDB, regfile), directions mirrored.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 3
);
  // issue stage
  logic                 issue_valid;
  logic [1:0]           issue_type;
  logic [4:0]           issue_rd;
  logic                 issue_ready;
  logic [31:0]          issue_val;
  logic                 full;
  logic [ROB_WIDTH-1:0] issue_rob_id;
  // common data bus writeback
  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_val;
  logic                 wb_mispred;
  logic [31:0]          wb_target;
  // regfile dependency lookups
  logic [ROB_WIDTH-1:0] search_rob_id_1;
  logic [ROB_WIDTH-1:0] search_rob_id_2;
  logic                 search_ready_1;
  logic                 search_ready_2;
  logic [31:0]          search_val_1;
  logic [31:0]          search_val_2;
  // retirement and flush
  logic [4:0]           commit_reg_id;
  logic [31:0]          commit_val;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 commit_store;
  logic                 clear;
  logic [31:0]          clear_pc;

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_ready, issue_val,
    input  wb_valid, wb_rob_id, wb_val, wb_mispred, wb_target,
    input  search_rob_id_1, search_rob_id_2,
    output full, issue_rob_id,
    output search_ready_1, search_ready_2, search_val_1, search_val_2,
    output commit_reg_id, commit_val, commit_rob_id, commit_store, clear, clear_pc
  );

  modport master (
    output issue_valid, issue_type, issue_rd, issue_ready, issue_val,
    output wb_valid, wb_rob_id, wb_val, wb_mispred, wb_target,
    output search_rob_id_1, search_rob_id_2,
    input  full, issue_rob_id,
    input  search_ready_1, search_ready_2, search_val_1, search_val_2,
    input  commit_reg_id, commit_val, commit_rob_id, commit_store, clear, clear_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Purpose: circular in-order-retire reorder buffer; allocates at tail, captures CDB results, retires at head.
// Latency: issue/writeback land on the next edge; a ready head retires on the following edge (registered commit).
// Backpressure: full blocks issue (decoder holds); rdy_in=0 freezes all state; mispredicted retire flushes.
// Ports: clk_in, rst_n_in (async, active-low), rdy_in (stall), rob_if (slave modport of reorder_buffer_if).
module reorder_buffer #(
  parameter int ROB_WIDTH = 3
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  reorder_buffer_if.slave   rob_if
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_JUMP   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        mispred;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] target;
  } rob_entry_t;

  rob_entry_t           r_ent [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic [4:0]           r_commit_reg_id;
  logic [31:0]          r_commit_val;
  logic [ROB_WIDTH-1:0] r_commit_rob_id;
  logic                 r_commit_store;
  logic                 r_clear;
  logic [31:0]          r_clear_pc;

  rob_entry_t w_head_ent;
  logic       w_full;
  logic       w_commit;
  logic       w_flush;
  logic       w_issue;
  logic       w_wb;

  // All decisions use state at cycle start: a writeback this cycle cannot
  // retire this cycle, and a full buffer rejects issue even if head retires.
  assign w_head_ent = r_ent[r_head];
  assign w_full     = (r_count == (ROB_WIDTH+1)'(DEPTH));
  assign w_commit   = w_head_ent.busy && w_head_ent.ready;
  assign w_flush    = w_commit && w_head_ent.mispred &&
                      (w_head_ent.typ == T_BRANCH || w_head_ent.typ == T_JUMP);
  assign w_issue    = rob_if.issue_valid && !w_full;
  assign w_wb       = rob_if.wb_valid && r_ent[rob_if.wb_rob_id].busy;

  // Entry storage. Issue targets a non-busy slot and writeback only busy
  // ones, so the two never collide; a flush drops both.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        // ready/val survive the flush, only ownership is dropped
        for (int i = 0; i < DEPTH; i++) r_ent[i].busy <= 1'b0;
      end else begin
        if (w_wb) begin
          r_ent[rob_if.wb_rob_id].ready   <= 1'b1;
          r_ent[rob_if.wb_rob_id].val     <= rob_if.wb_val;
          r_ent[rob_if.wb_rob_id].mispred <= rob_if.wb_mispred;
          r_ent[rob_if.wb_rob_id].target  <= rob_if.wb_target;
        end
        if (w_commit) r_ent[r_head].busy <= 1'b0;
        if (w_issue) begin
          r_ent[r_tail].busy    <= 1'b1;
          r_ent[r_tail].ready   <= rob_if.issue_ready;
          r_ent[r_tail].mispred <= 1'b0;
          r_ent[r_tail].typ     <= rob_type_e'(rob_if.issue_type);
          r_ent[r_tail].rd      <= rob_if.issue_rd;
          r_ent[r_tail].val     <= rob_if.issue_val;
          r_ent[r_tail].target  <= r_ent[r_tail].target;
        end
      end
    end
  end

  // Head/tail wrap naturally at DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_commit) r_head <= r_head + 1'b1;
        if (w_issue)  r_tail <= r_tail + 1'b1;
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Registered retire port. commit_val/commit_rob_id and clear_pc hold
  // between events; the pulse-style fields return to zero when idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_commit_reg_id <= '0;
      r_commit_val    <= '0;
      r_commit_rob_id <= '0;
      r_commit_store  <= 1'b0;
      r_clear         <= 1'b0;
      r_clear_pc      <= '0;
    end else if (rdy_in) begin
      if (w_commit) begin
        r_commit_rob_id <= r_head;
        r_commit_val    <= w_head_ent.val;
        r_commit_reg_id <= (w_head_ent.typ == T_REG || w_head_ent.typ == T_JUMP) ?
                           w_head_ent.rd : 5'd0;
        r_commit_store  <= (w_head_ent.typ == T_STORE);
      end else begin
        r_commit_reg_id <= '0;
        r_commit_store  <= 1'b0;
      end
      r_clear <= w_flush;
      if (w_flush) r_clear_pc <= w_head_ent.target;
    end
  end

  assign rob_if.full           = w_full;
  assign rob_if.issue_rob_id   = r_tail;
  // Lookups read stored entry state only; no forwarding from the CDB.
  assign rob_if.search_ready_1 = r_ent[rob_if.search_rob_id_1].ready;
  assign rob_if.search_val_1   = r_ent[rob_if.search_rob_id_1].val;
  assign rob_if.search_ready_2 = r_ent[rob_if.search_rob_id_2].ready;
  assign rob_if.search_val_2   = r_ent[rob_if.search_rob_id_2].val;
  assign rob_if.commit_reg_id  = r_commit_reg_id;
  assign rob_if.commit_val     = r_commit_val;
  assign rob_if.commit_rob_id  = r_commit_rob_id;
  assign rob_if.commit_store   = r_commit_store;
  assign rob_if.clear          = r_clear;
  assign rob_if.clear_pc       = r_clear_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose: self-checking bench for reorder_buffer with an in-bench program-order queue model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: exercises full, rdy_in stalls, mispredict flushes and async reset.
module tb_reorder_buffer;
  localparam int W = 3;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_WIDTH(W)) rif ();

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .rob_if   (rif)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: program-order list of live ids plus per-slot contents.
  int          q[$];
  int          m_tail;
  logic        m_ready [D];
  logic [31:0] m_val   [D];
  logic [1:0]  m_type  [D];
  logic [4:0]  m_rd    [D];
  logic        m_mis   [D];
  logic [31:0] m_tgt   [D];
  logic [4:0]  e_creg;
  logic [31:0] e_cval;
  logic [2:0]  e_cid;
  logic        e_cst;
  logic        e_clr;
  logic [31:0] e_cpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit live(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < D; i++) begin
      m_ready[i] = 0; m_val[i] = 0; m_type[i] = 0; m_rd[i] = 0; m_mis[i] = 0; m_tgt[i] = 0;
    end
    e_creg = 0; e_cval = 0; e_cid = 0; e_cst = 0; e_clr = 0; e_cpc = 0;
  endfunction

  // One clock edge of architectural behaviour, from the inputs present at the edge.
  function automatic void model_step();
    bit was_full;
    bit ret;
    int h;
    if (!rdy) return;
    was_full = (q.size() == D);
    ret = (q.size() > 0) && m_ready[q[0]];
    e_creg = 0; e_cst = 0; e_clr = 0;
    if (ret) begin
      h = q[0];
      e_cid  = h[2:0];
      e_cval = m_val[h];
      e_creg = (m_type[h] == 0 || m_type[h] == 3) ? m_rd[h] : 5'd0;
      e_cst  = (m_type[h] == 1);
      e_clr  = m_mis[h] && (m_type[h] >= 2);
      if (e_clr) begin
        e_cpc = m_tgt[h];
        q.delete();
        m_tail = 0;
        return;
      end
    end
    if (rif.wb_valid && live(int'(rif.wb_rob_id))) begin
      m_ready[rif.wb_rob_id] = 1;
      m_val[rif.wb_rob_id]   = rif.wb_val;
      m_mis[rif.wb_rob_id]   = rif.wb_mispred;
      m_tgt[rif.wb_rob_id]   = rif.wb_target;
    end
    if (ret) void'(q.pop_front());
    if (rif.issue_valid && !was_full) begin
      m_ready[m_tail] = rif.issue_ready;
      m_val[m_tail]   = rif.issue_val;
      m_type[m_tail]  = rif.issue_type;
      m_rd[m_tail]    = rif.issue_rd;
      m_mis[m_tail]   = 0;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % D;
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("full",          32'(rif.full),          32'(q.size() == D));
      chk("issue_rob_id",  32'(rif.issue_rob_id),  32'(m_tail));
      chk("commit_reg_id", 32'(rif.commit_reg_id), 32'(e_creg));
      chk("commit_val",    rif.commit_val,         e_cval);
      chk("commit_rob_id", 32'(rif.commit_rob_id), 32'(e_cid));
      chk("commit_store",  32'(rif.commit_store),  32'(e_cst));
      chk("clear",         32'(rif.clear),         32'(e_clr));
      chk("clear_pc",      rif.clear_pc,           e_cpc);
      chk("search_ready_1", 32'(rif.search_ready_1), 32'(m_ready[rif.search_rob_id_1]));
      chk("search_val_1",   rif.search_val_1,        m_val[rif.search_rob_id_1]);
      chk("search_ready_2", 32'(rif.search_ready_2), 32'(m_ready[rif.search_rob_id_2]));
      chk("search_val_2",   rif.search_val_2,        m_val[rif.search_rob_id_2]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    rif.issue_valid = 0;
    rif.wb_valid    = 0;
    rif.wb_mispred  = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy_i, input logic [31:0] v);
    rif.issue_valid = 1; rif.issue_type = t; rif.issue_rd = rd; rif.issue_ready = rdy_i; rif.issue_val = v;
  endtask

  task automatic wb(input logic [2:0] id, input logic [31:0] v, input logic mis, input logic [31:0] tgt);
    rif.wb_valid = 1; rif.wb_rob_id = id; rif.wb_val = v; rif.wb_mispred = mis; rif.wb_target = tgt;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_full",          32'(rif.full),          32'd0);
    chk("rst_issue_rob_id",  32'(rif.issue_rob_id),  32'd0);
    chk("rst_commit_reg_id", 32'(rif.commit_reg_id), 32'd0);
    chk("rst_clear",         32'(rif.clear),         32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int got[$];
    int order[8];
    model_reset();
    rif.issue_valid = 0; rif.issue_type = 0; rif.issue_rd = 0; rif.issue_ready = 0; rif.issue_val = 0;
    rif.wb_valid = 0; rif.wb_rob_id = 0; rif.wb_val = 0; rif.wb_mispred = 0; rif.wb_target = 0;
    rif.search_rob_id_1 = 0; rif.search_rob_id_2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_commit_val", rif.commit_val, 32'd0);
    chk("init_clear_pc",   rif.clear_pc,   32'd0);
    rst_n = 1;
    chk_en = 1;

    // Basic REG retire with lookup of the freed entry
    issue(2'd0, 5'd5, 1'b0, 32'hdead);  cyc();
    wb(3'd0, 32'h1234, 1'b0, 32'h0);    cyc();
    cyc();
    chk("s1_reg_id", 32'(rif.commit_reg_id), 32'd5);
    chk("s1_val",    rif.commit_val,         32'h1234);
    chk("s1_rob_id", 32'(rif.commit_rob_id), 32'd0);
    rif.search_rob_id_1 = 0;
    #1;
    chk("s1_search_ready", 32'(rif.search_ready_1), 32'd1);
    chk("s1_search_val",   rif.search_val_1,        32'h1234);

    // Fill, reject overflow, out-of-order writeback, in-order retire, wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'h0); cyc();
    end
    chk("s2_full", 32'(rif.full), 32'd1);
    issue(2'd0, 5'd30, 1'b0, 32'h0); cyc();
    chk("s2_full_after_9th", 32'(rif.full), 32'd1);
    chk("s2_tail_after_9th", 32'(rif.issue_rob_id), 32'd0);
    order = '{5, 2, 7, 0, 3, 6, 1, 4};
    for (int i = 0; i < 8; i++) begin
      wb(3'(order[i]), 32'(100 + order[i]), 1'b0, 32'h0); cyc();
      if (rif.commit_reg_id != 0) got.push_back(int'(rif.commit_rob_id));
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (rif.commit_reg_id != 0) got.push_back(int'(rif.commit_rob_id));
    end
    chk("s2_retire_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("s2_retire_order", (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff, 32'(i));
    chk("s2_wrap_id", 32'(rif.issue_rob_id), 32'd0);
    chk("s2_empty",   32'(rif.full),         32'd0);

    // Mispredicted branch flushes the younger REG
    do_reset();
    issue(2'd2, 5'd0, 1'b0, 32'h0);   cyc();
    issue(2'd0, 5'd3, 1'b0, 32'h0);   cyc();
    wb(3'd1, 32'h55, 1'b0, 32'h0);    cyc();
    wb(3'd0, 32'h0, 1'b1, 32'h100);   cyc();
    cyc();
    chk("s3_clear",    32'(rif.clear),         32'd1);
    chk("s3_clear_pc", rif.clear_pc,           32'h100);
    chk("s3_reg_id",   32'(rif.commit_reg_id), 32'd0);
    chk("s3_rob_id",   32'(rif.commit_rob_id), 32'd0);
    chk("s3_tail",     32'(rif.issue_rob_id),  32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s3_clear_low", 32'(rif.clear),         32'd0);
      chk("s3_pc_hold",   rif.clear_pc,           32'h100);
      chk("s3_no_id1",    32'(rif.commit_reg_id), 32'd0);
    end

    // Store retire pulse
    issue(2'd1, 5'd0, 1'b0, 32'h0);  cyc();
    wb(3'd0, 32'h9, 1'b0, 32'h0);    cyc();
    cyc();
    chk("s4_store",  32'(rif.commit_store),  32'd1);
    chk("s4_reg_id", 32'(rif.commit_reg_id), 32'd0);
    cyc();
    chk("s4_store_pulse", 32'(rif.commit_store), 32'd0);

    // Stall with ready head, retire on the first cycle after release
    issue(2'd0, 5'd7, 1'b1, 32'habcd); cyc();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s5_stall_reg_id", 32'(rif.commit_reg_id), 32'd0);
      chk("s5_stall_tail",   32'(rif.issue_rob_id),  32'd2);
    end
    rdy = 1;
    cyc();
    chk("s5_reg_id", 32'(rif.commit_reg_id), 32'd7);
    chk("s5_val",    rif.commit_val,         32'habcd);
    chk("s5_rob_id", 32'(rif.commit_rob_id), 32'd1);

    // Randomized traffic against the model, with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) != 0) begin
        logic [1:0] t;
        t = 2'($urandom_range(0, 3));
        issue(t, (t == 0 || t == 3) ? 5'($urandom_range(1, 31)) : 5'd0,
              ($urandom_range(0, 3) == 0), $urandom);
      end
      if ($urandom_range(0, 1) != 0) begin
        logic [2:0] id;
        if (q.size() > 0 && $urandom_range(0, 7) != 0) id = 3'(q[$urandom_range(0, q.size() - 1)]);
        else id = 3'($urandom_range(0, 7));
        wb(id, $urandom, ($urandom_range(0, 7) == 0), $urandom);
      end
      rif.search_rob_id_1 = 3'($urandom_range(0, 7));
      rif.search_rob_id_2 = 3'($urandom_range(0, 7));
      cyc();
    end
    rdy = 1;
    cyc();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
